// File: rtl/key_pkg.sv
// Shared keypad definitions: matrix geometry, FSM states and the scan-snapshot
// classifier used by key_scan.
package key_pkg;

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD,
        RELEASE
    } key_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_class_t;

    typedef struct packed {
        scan_class_t             cls;
        logic [KEY_CODE_W-1:0]   code;
    } scan_result_t;

    // Counts pressed bits; the code is only meaningful for SCAN_SINGLE.
    function automatic scan_result_t classify(input logic [KEY_ROWS*KEY_COLS-1:0] snap);
        scan_result_t r;
        int           n;
        n      = 0;
        r.code = '0;
        r.cls  = SCAN_NONE;
        for (int i = 0; i < KEY_ROWS * KEY_COLS; i++) begin
            if (snap[i]) begin
                n      = n + 1;
                r.code = KEY_CODE_W'(i);
            end
        end
        if (n == 1) begin
            r.cls = SCAN_SINGLE;
        end else if (n > 1) begin
            r.cls = SCAN_MULTI;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks; shared
// with the display scanner.
module scan_tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        tick  = (div_q == LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: row drive, column sampling, scan-level debounce and a
// valid/ready key-code output with sticky overflow.
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [KEY_COLS-1:0]   col_n,
    output logic [KEY_ROWS-1:0]   row_n,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  key_held,
    output logic                  key_ovf
);

    localparam int SNAP_W = KEY_ROWS * KEY_COLS;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic                  tick;
    logic                  scan_end;
    logic                  emit;
    scan_result_t          res;

    logic [KEY_COLS-1:0]   col_meta_q,  col_meta_d;
    logic [KEY_COLS-1:0]   col_sync_q,  col_sync_d;
    logic [1:0]            row_idx_q,   row_idx_d;
    logic [KEY_ROWS-1:0]   row_n_q,     row_n_d;
    logic [SNAP_W-1:0]     snap_q,      snap_d;
    key_state_t            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [KEY_CODE_W-1:0] cand_q,      cand_d;
    logic [KEY_CODE_W-1:0] key_code_q,  key_code_d;
    logic                  key_valid_q, key_valid_d;
    logic                  key_ovf_q,   key_ovf_d;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick    (tick)
    );

    // Input synchronizer, row sequencing and snapshot capture.
    // The sample is taken before row_idx advances, so it belongs to the row
    // that has been driven for the whole slot.
    always_comb begin
        col_meta_d = col_n;
        col_sync_d = col_meta_q;
        row_idx_d  = row_idx_q;
        snap_d     = snap_q;
        if (tick) begin
            snap_d[{row_idx_q, 2'b00} +: KEY_COLS] = ~col_sync_q;
            row_idx_d = row_idx_q + 2'd1;
        end
        row_n_d  = ~(4'b0001 << row_idx_d);
        scan_end = tick && (row_idx_q == 2'd3);
        res      = classify(snap_d);
    end

    // Debounce FSM, stepped once per completed scan.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        emit    = 1'b0;
        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (res.cls == SCAN_SINGLE) begin
                        state_d = CONFIRM;
                        cand_d  = res.code;
                        cnt_d   = CNT_ONE;
                    end
                end
                CONFIRM: begin
                    if (res.cls == SCAN_SINGLE && res.code == cand_q) begin
                        cnt_d = sat_inc(cnt_q);
                        if (cnt_d >= CNT_DONE) begin
                            state_d = HELD;
                            emit    = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (res.cls == SCAN_NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (res.cls == SCAN_NONE) begin
                        cnt_d = sat_inc(cnt_q);
                        if (cnt_d >= CNT_DONE) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output handshake; an emit that finds a code still pending is dropped
    // and recorded in the sticky overflow flag.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_ovf_d   = key_ovf_q;
        if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = cand_q;
                key_valid_d = 1'b1;
            end else begin
                key_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            row_idx_q   <= 2'd0;
            row_n_q     <= 4'b1110;
            snap_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_ovf_q   <= 1'b0;
        end else begin
            col_meta_q  <= col_meta_d;
            col_sync_q  <= col_sync_d;
            row_idx_q   <= row_idx_d;
            row_n_q     <= row_n_d;
            snap_q      <= snap_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_ovf_q   <= key_ovf_d;
        end
    end

    assign row_n     = row_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_ovf   = key_ovf_q;
    assign key_held  = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_key_scan.sv
// Randomized and directed bench for key_scan with a keypad model driving the
// columns and a scan-level reference model of press/release acceptance.
module tb_key_scan;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int SCAN_CYC       = 4 * SCAN_DIV;
    localparam int NEED           = (DEBOUNCE_SCANS < 2) ? 2 : DEBOUNCE_SCANS;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        key_ovf;
    logic [15:0] key_mask;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (scan granularity).
    bit         m_down;
    int         m_run;
    int         m_rel;
    logic [3:0] m_run_code;
    logic [3:0] m_code;
    bit         m_pending;
    bit         m_ovf;

    int         cyc = 0;
    int         rises = 0;
    int         rise_cyc = 0;
    logic       prev_vld = 1'b0;

    key_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .key_ovf   (key_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    // Passive keypad: a pressed key shorts its column to the row driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (key_valid && !prev_vld) begin
            rises    <= rises + 1;
            rise_cyc <= cyc;
        end
        prev_vld <= key_valid;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_down = 0; m_run = 0; m_rel = 0; m_run_code = 0;
        m_code = 0; m_pending = 0; m_ovf = 0;
    endtask

    // One full scan with a fixed key set and a fixed ready level.
    task automatic model_scan(input logic [15:0] mask, input bit rdy);
        int         n;
        logic [3:0] code;
        if (m_pending && rdy) m_pending = 0;
        n    = $countones(mask);
        code = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) code = 4'(i);
        if (!m_down) begin
            if (n == 1) begin
                if (m_run == 0) begin
                    m_run = 1;
                    m_run_code = code;
                end else if (code == m_run_code) begin
                    m_run++;
                end else begin
                    m_run = 0;
                end
                if (m_run >= NEED) begin
                    m_down = 1; m_rel = 0; m_run = 0;
                    if (!m_pending) begin
                        m_code = code;
                        m_pending = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel++;
                if (m_rel >= DEBOUNCE_SCANS) m_down = 0;
            end else begin
                m_rel = 0;
            end
        end
    endtask

    // Called #1 after a scan-boundary edge; returns #1 after the next one.
    task automatic scan_step(input logic [15:0] mask, input bit rdy);
        bit had_pend;
        had_pend  = m_pending;
        key_mask  = mask;
        key_ready = rdy;
        @(posedge sys_clk);
        #1;
        if (had_pend && rdy) chk("valid_fall", 32'(key_valid), 0);
        repeat (SCAN_CYC - 1) @(posedge sys_clk);
        #1;
        model_scan(mask, rdy);
        chk("row_n_scan_start", 32'(row_n), 32'hE);
        chk("key_held",  32'(key_held),  32'(m_down));
        chk("key_valid", 32'(key_valid), 32'(m_pending));
        chk("key_code",  32'(key_code),  32'(m_code));
        chk("key_ovf",   32'(key_ovf),   32'(m_ovf));
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        key_mask  = '0;
        key_ready = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int         base_rises;
        int         press_cyc;
        int         lat;
        int         sel;
        int         k1;
        int         k2;
        logic [15:0] cur;

        sys_rst   = 1'b1;
        key_mask  = '0;
        key_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Reset mid-scan while row 2 is driven.
        repeat (9) @(posedge sys_clk);
        #1 chk("pre_rst_row", 32'(row_n), 32'hB);
        #2 sys_rst = 1'b1;
        #1;
        chk("rst_row_n", 32'(row_n), 32'hE);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_held",  32'(key_held), 0);
        chk("rst_ovf",   32'(key_ovf), 0);
        chk("rst_code",  32'(key_code), 0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (SCAN_DIV - 1) @(posedge sys_clk);
        #1 chk("row_hold", 32'(row_n), 32'hE);
        @(posedge sys_clk);
        #1 chk("row_first_change", 32'(row_n), 32'hD);

        // Key 9 held, ready high: one emission, bounded latency.
        do_reset();
        base_rises = rises;
        press_cyc  = cyc;
        repeat (5) scan_step(16'h0200, 1'b1);
        lat = rise_cyc - press_cyc;
        chk("lat9_in_window", 32'((lat >= DEBOUNCE_SCANS * SCAN_CYC) && (lat <= (DEBOUNCE_SCANS + 1) * SCAN_CYC + 3)), 1);
        repeat (4) scan_step(16'h0000, 1'b1);
        chk("key9_one_emit", 32'(rises - base_rises), 1);

        // Short press of key 5, then a real press of key 5.
        base_rises = rises;
        repeat (2) scan_step(16'h0020, 1'b1);
        repeat (2) scan_step(16'h0000, 1'b1);
        chk("short_no_emit", 32'(rises - base_rises), 0);
        repeat (3) scan_step(16'h0020, 1'b1);
        repeat (3) scan_step(16'h0000, 1'b1);

        // Ghosting: keys 0 and 5 together, then key 0 alone.
        base_rises = rises;
        repeat (4) scan_step(16'h0021, 1'b1);
        chk("multi_no_emit", 32'(rises - base_rises), 0);
        repeat (4) scan_step(16'h0001, 1'b1);
        repeat (3) scan_step(16'h0000, 1'b1);
        chk("multi_then_0", 32'(key_code), 0);

        // Consumer stalled: second press overflows, first code kept.
        do_reset();
        repeat (3) scan_step(16'h0008, 1'b0);
        repeat (3) scan_step(16'h0000, 1'b0);
        repeat (3) scan_step(16'h0080, 1'b0);
        repeat (3) scan_step(16'h0000, 1'b0);
        chk("ovf_code_kept", 32'(key_code), 3);
        chk("ovf_sticky", 32'(key_ovf), 1);
        scan_step(16'h0000, 1'b1);

        // One-scan release glitch while held.
        base_rises = rises;
        repeat (3) scan_step(16'h0004, 1'b1);
        scan_step(16'h0000, 1'b1);
        repeat (2) scan_step(16'h0004, 1'b1);
        repeat (3) scan_step(16'h0000, 1'b1);
        chk("glitch_one_emit", 32'(rises - base_rises), 1);

        // Random key activity against the reference model.
        do_reset();
        cur = '0;
        for (int s = 0; s < 250; s++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 5 && sel <= 6) begin
                cur = '0;
            end else if (sel >= 7 && sel <= 8) begin
                cur = '0;
                cur[$urandom_range(0, 15)] = 1'b1;
            end else if (sel == 9) begin
                k1  = $urandom_range(0, 15);
                k2  = (k1 + 1 + $urandom_range(0, 14)) % 16;
                cur = '0;
                cur[k1] = 1'b1;
                cur[k2] = 1'b1;
            end
            scan_step(cur, ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
